// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and sizing helpers for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int SUB_WIDTH = 4;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

    function automatic int sub_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: single-bit full adder cell
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, through one full-adder cell (b inverted, carry seeded 1)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = sub_cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d, overflow_q, overflow_d, zero_q, zero_d;
    logic             s, cout, last;
    logic [WIDTH-1:0] final_diff;

    full_adder_1bit u_fa (
        .a   (sa_q[0]),
        .b   (~sb_q[0]),
        .cin (carry_q),
        .s   (s),
        .cout(cout)
    );

    assign last       = (count_q == CW'(WIDTH - 1));
    assign final_diff = {s, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        sr_d       = sr_q;
        count_d    = count_q;
        carry_d    = carry_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sa_d    = a;
                sb_d    = b;
                carry_d = 1'b1;
                count_d = '0;
            end
            RUN: begin
                sr_d    = final_diff;
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                carry_d = cout;
                count_d = count_q + 1'b1;
                // On the MSB step sa_q[0]/sb_q[0] still hold the operand sign bits
                if (last) begin
                    state_d    = DONE;
                    diff_d     = final_diff;
                    borrow_d   = ~cout;
                    overflow_d = (sa_q[0] != sb_q[0]) && (s != sa_q[0]);
                    zero_d     = (final_diff == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            sr_q       <= '0;
            count_q    <= '0;
            carry_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            sr_q       <= sr_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, borrow, overflow, zero;
    logic [WIDTH-1:0] diff;

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] prev_diff = '0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .overflow(overflow),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input bit restart);
        int n, bc, sd;
        logic [WIDTH-1:0] ed;
        ed = ta - tb_v;
        sd = int'($signed(ta)) - int'($signed(tb_v));
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
        n = 0; bc = 0;
        while (done !== 1'b1 && n < 3 * WIDTH) begin
            if (busy === 1'b1) bc++;
            check("diff_hold_run", diff, prev_diff);
            if (restart && n == 1) begin
                start = 1'b1; a = 4'd0; b = 4'd1;
            end else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done", done, 1);
        check("busy_cycles", bc, WIDTH);
        check("busy_in_done", busy, 0);
        check("diff", diff, ed);
        check("borrow", borrow, (ta < tb_v) ? 1 : 0);
        check("overflow", overflow, (sd < -(1 << (WIDTH - 1)) || sd > (1 << (WIDTH - 1)) - 1) ? 1 : 0);
        check("zero", zero, (ed == 0) ? 1 : 0);
        prev_diff = ed;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("diff_hold_idle", diff, ed);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_overflow", overflow, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd9, 4'd3, 1'b0);
        do_op(4'd3, 4'd9, 1'b0);
        do_op(4'd7, 4'd8, 1'b0);
        do_op(4'd5, 4'd5, 1'b0);
        do_op(4'd8, 4'd1, 1'b0);
        do_op(4'd9, 4'd3, 1'b1);
        do_op(4'd8, 4'd1, 1'b0);

        @(negedge clk);
        a = 4'd9; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_overflow", overflow, 0);
        check("abort_zero", zero, 0);
        prev_diff = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd9, 4'd3, 1'b0);

        for (int i = 0; i < 256; i++) do_op(WIDTH'(i >> 4), WIDTH'(i), 1'b0);
        for (int i = 0; i < 40; i++) do_op(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
